// File: rtl/eth_wb_mem_slave.sv
// rtl/eth_wb_mem_slave.sv - Wishbone B3 burst memory slave for the Ethernet MAC DMA port
// Registered ack/err; a beat "fires" on the edge that registers its termination.
module eth_wb_mem_slave #(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [15:0] rd_beats_o,
    output logic [15:0] wr_beats_o,
    output logic [7:0]  err_cnt_o
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] ptr_q, ptr_cur, ptr_adv;
    logic [3:0]        cnt_q;
    logic              we_q, bad_q, ovf_q;
    logic              req, addr_bad, we_cur, err_beat, last_beat, fire;

    assign req      = wb_cyc_i & wb_stb_i;
    assign addr_bad = (wb_adr_i[1:0] != 2'b00) ||
                      (wb_adr_i[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);

    // With no wait states the first beat fires from IDLE, so its attributes come off the bus.
    assign ptr_cur   = (state_q == S_IDLE) ? wb_adr_i[ADDR_W+1:2] : ptr_q;
    assign we_cur    = (state_q == S_IDLE) ? wb_we_i : we_q;
    assign err_beat  = (state_q == S_IDLE) ? addr_bad : (bad_q | ovf_q);
    assign last_beat = err_beat | (wb_cti_i != 3'b010);

    always_comb begin
        ptr_adv = ptr_cur + 1'b1;
        case (wb_bte_i)
            2'b01:   ptr_adv = {ptr_cur[ADDR_W-1:2], ptr_cur[1:0] + 2'd1};
            2'b10:   ptr_adv = {ptr_cur[ADDR_W-1:3], ptr_cur[2:0] + 3'd1};
            2'b11:   ptr_adv = {ptr_cur[ADDR_W-1:4], ptr_cur[3:0] + 4'd1};
            default: ptr_adv = ptr_cur + 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) fire = 1'b1;
                    else                  state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    if (wb_stb_i) fire = 1'b1;
                    else          state_d = S_BEAT;
                end
            end
            S_BEAT:  fire = wb_stb_i;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (fire) state_d = last_beat ? S_DONE : S_BEAT;
        if (!wb_cyc_i) begin
            state_d = S_IDLE;
            fire    = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr_q      <= '0;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            bad_q      <= 1'b0;
            ovf_q      <= 1'b0;
            wb_ack_o   <= 1'b0;
            wb_err_o   <= 1'b0;
            wb_dat_o   <= 32'd0;
            rd_beats_o <= 16'd0;
            wr_beats_o <= 16'd0;
            err_cnt_o  <= 8'd0;
        end else begin
            wb_ack_o <= fire & ~err_beat;
            wb_err_o <= fire & err_beat;
            if (state_q == S_IDLE && req) begin
                ptr_q <= wb_adr_i[ADDR_W+1:2];
                we_q  <= wb_we_i;
                bad_q <= addr_bad;
                ovf_q <= 1'b0;
                cnt_q <= 4'(WAIT_STATES);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (fire) begin
                ptr_q <= ptr_adv;
                // A linear burst stepping off the last word errors on its next beat.
                ovf_q <= (wb_bte_i == 2'b00) && (&ptr_cur);
                if (err_beat) begin
                    err_cnt_o <= (err_cnt_o == 8'hFF) ? 8'hFF : err_cnt_o + 8'd1;
                end else if (we_cur) begin
                    wr_beats_o <= wr_beats_o + 16'd1;
                end else begin
                    rd_beats_o <= rd_beats_o + 16'd1;
                    wb_dat_o   <= mem[ptr_cur];
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i && fire && we_cur && !err_beat) begin
            for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) mem[ptr_cur][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_eth_wb_mem_slave.sv
// tb/tb_eth_wb_mem_slave.sv - directed self-checking bench for eth_wb_mem_slave
module tb_eth_wb_mem_slave;
    localparam int WS   = 1;
    localparam int NCYC = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [15:0] rd_beats, wr_beats;
    logic [7:0]  err_cnt;

    eth_wb_mem_slave #(.ADDR_W(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(WS)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err),
        .rd_beats_o(rd_beats), .wr_beats_o(wr_beats), .err_cnt_o(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Model: word memory plus the per-cycle response schedule implied by the timing rules.
    logic [31:0] mem_m [1024];
    bit          exp_ack [NCYC];
    bit          exp_err [NCYC];
    bit          exp_rd  [NCYC];
    bit          exp_clr [NCYC];
    logic [31:0] exp_dat [NCYC];
    int          m_rd, m_wr, m_err;
    int          vectors, miscompares;
    bit          chk_en, resp_seen;
    int          first_resp, req_at;
    logic [31:0] rd_log [$];
    logic [31:0] bd [16];
    logic [3:0]  bs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc_n);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc_n < NCYC) begin
            if (exp_clr[cyc_n]) begin
                m_rd = 0; m_wr = 0; m_err = 0;
            end
            if (exp_ack[cyc_n]) begin
                if (exp_rd[cyc_n]) m_rd = (m_rd + 1) % 65536;
                else               m_wr = (m_wr + 1) % 65536;
            end
            if (exp_err[cyc_n] && m_err < 255) m_err++;
            check("ack", 32'(ack), 32'(exp_ack[cyc_n]));
            check("err", 32'(err), 32'(exp_err[cyc_n]));
            if (exp_ack[cyc_n] && exp_rd[cyc_n]) begin
                check("rdata", rdat, exp_dat[cyc_n]);
                rd_log.push_back(rdat);
            end
            check("rd_beats", 32'(rd_beats), 32'(m_rd));
            check("wr_beats", 32'(wr_beats), 32'(m_wr));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
            if ((ack || err) && !resp_seen) begin
                first_resp = cyc_n;
                resp_seen  = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0;
        wdat = 32'd0; sel = 4'd0; cti = 3'd0; bte = 2'd0;
    endtask

    task automatic present(input int j, input int n);
        wdat = bd[j];
        sel  = bs[j];
        cti  = (n == 1) ? 3'b000 : (j == n - 1) ? 3'b111 : 3'b010;
    endtask

    // Master drives beat j+1 during the cycle in which beat j is acked.
    task automatic xfer(input logic we_b, input logic [31:0] a, input logic [1:0] bt, input int n,
                        input int stall_after, input int abort_after, input int rst_at, input bit hold);
        int k, w, start, span;
        bit berr, fin;
        start = int'(a[31:2]);
        span  = (bt == 2'b01) ? 4 : (bt == 2'b10) ? 8 : (bt == 2'b11) ? 16 : 0;
        req_at = cyc_n;
        cyc = 1'b1; stb = 1'b1; we = we_b; adr = a; bte = bt;
        present(0, n);
        repeat (1 + WS) tick();
        fin = 1'b0;
        for (int j = 0; j < n && !fin; j++) begin
            k = cyc_n;
            w = (span == 0) ? start + j : (start / span) * span + (start + j) % span;
            berr = (a[1:0] != 2'b00) || (w >= 1024);
            if (berr) begin
                exp_err[k] = 1'b1;
            end else begin
                exp_ack[k] = 1'b1;
                exp_rd[k]  = !we_b;
                if (we_b) begin
                    for (int b = 0; b < 4; b++)
                        if (bs[j][b]) mem_m[w][8*b +: 8] = bd[j][8*b +: 8];
                end else begin
                    exp_dat[k] = mem_m[w];
                end
            end
            if (rst_at == j) begin
                rst = 1'b1;
                tick();
                exp_clr[cyc_n] = 1'b1;
                rst = 1'b0;
                bus_idle();
                check("rst_ack", 32'(ack), 32'd0);
                check("rst_rd_beats", 32'(rd_beats), 32'd0);
                fin = 1'b1;
            end else if (berr || j == n - 1 || abort_after == j + 1) begin
                if (hold) tick();
                bus_idle();
                fin = 1'b1;
            end else begin
                if (stall_after == j) begin
                    stb = 1'b0;
                    tick();
                    tick();
                    stb = 1'b1;
                end
                present(j + 1, n);
                tick();
            end
        end
        tick();
    endtask

    initial begin
        bus_idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_dat", rdat, 32'd0);
        check("reset_counters", {rd_beats, wr_beats}, 32'd0);

        bd[0] = 32'hDEADBEEF; bs[0] = 4'hF;
        resp_seen = 1'b0;
        xfer(1'b1, 32'h10, 2'b00, 1, -1, -1, -1, 1'b0);
        check("ack_latency", 32'(first_resp - req_at), 32'd2);
        rd_log.delete();
        xfer(1'b0, 32'h10, 2'b00, 1, -1, -1, -1, 1'b0);
        check("classic_rdata", rd_log[0], 32'hDEADBEEF);
        check("classic_wr_beats", 32'(wr_beats), 32'd1);
        check("classic_rd_beats", 32'(rd_beats), 32'd1);

        bd[0] = 32'h11223344; bs[0] = 4'b0101;
        xfer(1'b1, 32'h10, 2'b00, 1, -1, -1, -1, 1'b0);
        rd_log.delete();
        xfer(1'b0, 32'h10, 2'b00, 1, -1, -1, -1, 1'b1);
        check("byte_en_rdata", rd_log[0], 32'hDE22BE44);

        bd[0] = 32'h55550005; bd[1] = 32'h66660006; bd[2] = 32'h77770007;
        for (int i = 0; i < 3; i++) bs[i] = 4'hF;
        xfer(1'b1, 32'h14, 2'b00, 3, -1, -1, -1, 1'b0);
        rd_log.delete();
        xfer(1'b0, 32'h18, 2'b01, 4, -1, -1, -1, 1'b0);
        check("wrap4_count", 32'(rd_log.size()), 32'd4);
        check("wrap4_beat0", rd_log[0], 32'h66660006);
        check("wrap4_beat1", rd_log[1], 32'h77770007);
        check("wrap4_beat2", rd_log[2], 32'hDE22BE44);
        check("wrap4_beat3", rd_log[3], 32'h55550005);

        xfer(1'b0, 32'h1002, 2'b00, 1, -1, -1, -1, 1'b0);
        check("err_misaligned", 32'(err_cnt), 32'd1);
        xfer(1'b0, 32'h1000, 2'b00, 1, -1, -1, -1, 1'b0);
        check("err_window", 32'(err_cnt), 32'd2);

        for (int i = 0; i < 4; i++) begin bd[i] = 32'hA000_0040 + i; bs[i] = 4'hF; end
        xfer(1'b1, 32'h100, 2'b00, 4, 1, -1, -1, 1'b0);
        xfer(1'b0, 32'h100, 2'b00, 4, -1, -1, -1, 1'b0);

        for (int i = 0; i < 4; i++) bd[i] = 32'hB000_0080 + i;
        xfer(1'b1, 32'h200, 2'b00, 4, -1, -1, -1, 1'b0);
        for (int i = 0; i < 4; i++) bd[i] = 32'hC000_0080 + i;
        xfer(1'b1, 32'h200, 2'b00, 4, -1, 2, -1, 1'b0);
        rd_log.delete();
        xfer(1'b0, 32'h200, 2'b00, 4, -1, -1, -1, 1'b0);
        check("abort_word0", rd_log[0], 32'hC0000080);
        check("abort_word2", rd_log[2], 32'hB0000082);

        bd[0] = 32'h0000_03FE; bd[1] = 32'h0000_03FF;
        xfer(1'b1, 32'hFF8, 2'b00, 2, -1, -1, -1, 1'b0);
        xfer(1'b0, 32'hFF8, 2'b00, 3, -1, -1, -1, 1'b0);
        check("err_burst_end", 32'(err_cnt), 32'd3);

        for (int i = 0; i < 260; i++) xfer(1'b0, 32'h2000, 2'b00, 1, -1, -1, -1, 1'b0);
        check("err_saturate", 32'(err_cnt), 32'd255);

        xfer(1'b0, 32'h100, 2'b00, 8, -1, -1, 2, 1'b0);
        check("post_rst_counters", {rd_beats, wr_beats}, 32'd0);
        check("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        rd_log.delete();
        xfer(1'b0, 32'h100, 2'b00, 1, -1, -1, -1, 1'b0);
        check("post_rst_rdata", rd_log[0], 32'hA0000040);
        check("post_rst_rd_beats", 32'(rd_beats), 32'd1);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/eth_wb_mem_slave.md
# eth_wb_mem_slave

Wishbone B3 memory slave for the Ethernet MAC's DMA master port (`m_wb_*`). It serves buffer-descriptor and frame-data reads and writes issued by the MAC. It sits directly downstream of the MAC's master interface in the top-level wiring. It supports classic cycles and incrementing/wrapping bursts (CTI/BTE), programmable wait states, error response on out-of-window or misaligned access, and access statistics for the bench.

## Interface
- `ADDR_W`, 10: word-address width; memory is 2^ADDR_W × 32 bit.
- `BASE_ADDR`, 32'h0000_0000: byte base of window; must be aligned to 4·2^ADDR_W.
- `WAIT_STATES`, 1: cycles inserted before the first ack of each cycle/burst; legal range 0..15.

Ports:
- `wb_clk_i` in 1: clock. One clock domain.
- `wb_rst_i` in 1: reset, synchronous, active-high.
- `wb_adr_i` in 32: byte address (from `m_wb_adr_o`).
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte enables; bit n enables `dat[8n+7:8n]`.
- `wb_we_i` in 1: 1 = write.
- `wb_cyc_i` in 1: bus cycle active.
- `wb_stb_i` in 1: strobe.
- `wb_cti_i` in 3: 000 classic, 010 incrementing burst, 111 end-of-burst.
- `wb_bte_i` in 2: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- `wb_dat_o` out 32: read data, valid when `wb_ack_o & ~wb_we_i`.
- `wb_ack_o` out 1: normal termination.
- `wb_err_o` out 1: error termination.
- `rd_beats_o` out 16: acked read beats, wraps mod 2^16.
- `wr_beats_o` out 16: acked write beats, wraps mod 2^16.
- `err_cnt_o` out 8: error terminations, saturates at 255.

## Operation
- States: IDLE, WAIT, BEAT, DONE.
- **IDLE**
  - On `cyc & stb`, latch `wb_adr_i[ADDR_W+1:2]` into internal word pointer `ptr` and latch `wb_we_i`.
  - Load the wait counter with `WAIT_STATES`.
  - Go to WAIT, or directly to BEAT if `WAIT_STATES = 0`.
- **Address check** (request is error if either holds):
  - `wb_adr_i[1:0] != 0`.
  - `wb_adr_i` lies outside `[BASE_ADDR, BASE_ADDR + 4·2^ADDR_W)`.
  - An error request still honours wait states, then asserts `wb_err_o` instead of ack, increments `err_cnt_o`, and goes to DONE. Memory is never written on error.
- **WAIT**: decrement the counter each cycle; at 0 go to BEAT. `cyc` low → IDLE, no termination.
- **BEAT**
  - Drive `ack = 1` each cycle that `stb = 1`. No ack while `stb = 0`; hold the state.
  - Write beat: for each set `sel` bit, store that byte of `wb_dat_i` at `mem[ptr]`.
  - Read beat: `wb_dat_o = mem[ptr]`.
  - After each acked beat, advance `ptr`: linear +1; wrapN increments the low log2(N) bits only (mod N).
  - Termination:
    - Classic (`cti = 000`): one beat, then DONE.
    - `cti = 010`: stay in BEAT with back-to-back acks.
    - `cti = 111`: that beat is last, then DONE.
  - Burst address check: if a linear burst advances `ptr` past the window end, the next beat is an err beat, then DONE.
- **DONE**: one dead cycle with `ack = err = 0`; `stb` still high here is not a new request. Then IDLE.
- `cyc` falling in any state → IDLE next cycle, outputs low.
- `wb_adr_i` is ignored after the first beat of a burst; `ptr` is authoritative.
- Counters increment once per acked beat by direction.

## Timing
- Reset values:
  - Outputs: `wb_ack_o = 0`, `wb_err_o = 0`, `wb_dat_o = 0`, all counters 0.
  - State: IDLE, `ptr = 0`.
  - Memory contents are not reset.
- `ack`, `err` and `dat_o` are registered outputs.
- Latency: request sampled at edge N → first ack high in the cycle following edge N+WAIT_STATES. With `WAIT_STATES = 0` the ack is in the cycle after edge N.
- Burst throughput: 1 beat/cycle after the first ack while `stb` is held.
- Minimum spacing between classic cycles: 2 + WAIT_STATES cycles.
- `wb_rst_i` mid-cycle:
  - Next cycle is IDLE with no ack or err.
  - A partially completed burst leaves earlier written beats in memory.
- `ack` and `err` are never high together. Neither is asserted when `cyc = 0`.

## Test plan
- Setup: `WAIT_STATES = 1`, `BASE_ADDR = 0`.
- **Classic write/read**: write 0xDEADBEEF to 0x10 with `sel = 1111`, then read 0x10 → `ack` 2 cycles after `stb`, read data 0xDEADBEEF, `wr_beats = rd_beats = 1`.
- **Byte enables**: on 0x10, write 0x11223344 with `sel = 0101` → read returns 0xDE22BE44.
- **Wrap4 read burst**: start at 0x18, `bte = 01`, four beats, last with `cti = 111` → word addresses 6,7,4,5; acks on 4 consecutive cycles after the first; then DONE.
- **Errors**:
  - Read 0x1002 (misaligned) → `err`, no ack, `err_cnt = 1`.
  - Read 0x1000 with `ADDR_W = 10` → `err`, `err_cnt = 2`.
- **Burst stall and abort**:
  - In a linear write burst, drop `stb` for 2 cycles → no ack in those cycles, burst resumes at the same `ptr`.
  - Drop `cyc` after 2 beats → exactly 2 words written, IDLE.
- **Reset mid-burst**: assert `wb_rst_i` during beat 3 of an 8-beat read → `ack` low the next cycle, counters 0, a new classic read works normally.
